// File: rtl/merge_accum_pkg.sv
// -----------------------------------------------------------------------------
// merge_accum_pkg
// Shared definitions for the tile-clock partial-sum merge stage:
//   QW         lane width (signed two's complement partial sums)
//   DEF_XW     default number of lanes per vector
//   DEF_CNT_W  default width of the emitted-vector counter
//   SAT_MAX    largest representable QW-bit signed value
//   SAT_MIN    smallest representable QW-bit signed value
// No ports; imported by merge_accum and sat_add_lane.
// -----------------------------------------------------------------------------
package merge_accum_pkg;

  localparam int QW        = 8;
  localparam int DEF_XW    = 128;
  localparam int DEF_CNT_W = 16;

  localparam logic [QW-1:0] SAT_MAX = {1'b0, {(QW-1){1'b1}}};
  localparam logic [QW-1:0] SAT_MIN = {1'b1, {(QW-1){1'b0}}};

  typedef logic [QW-1:0] lane_t;

endpackage : merge_accum_pkg

// File: rtl/merge_accum_sat_add_lane.sv
// -----------------------------------------------------------------------------
// sat_add_lane
// Combinational QW-bit signed saturating adder for one lane.
// Ports:
//   i_a, i_b  in   QW-bit signed operands
//   o_sum     out  i_a + i_b clamped to [SAT_MIN, SAT_MAX]
//   o_sat     out  1 when the clamp was applied
// -----------------------------------------------------------------------------
module sat_add_lane
  import merge_accum_pkg::*;
(
  input  lane_t i_a,
  input  lane_t i_b,
  output lane_t o_sum,
  output logic  o_sat
);

  logic [QW:0] w_wide;

  // Sign-extend by one bit so the true sum always fits.
  assign w_wide = {i_a[QW-1], i_a} + {i_b[QW-1], i_b};

  // The two top bits disagree exactly when the sum left the QW-bit range;
  // the extra top bit then carries the true sign and picks the bound.
  assign o_sat = w_wide[QW] ^ w_wide[QW-1];
  assign o_sum = !o_sat ? w_wide[QW-1:0] : (w_wide[QW] ? SAT_MIN : SAT_MAX);

endmodule : sat_add_lane

// File: rtl/merge_accum.sv
// -----------------------------------------------------------------------------
// merge_accum
// Tile-clock partial-sum merge stage between the crossbar result path and
// merge_io. Joins a local vector with a remote vector (merge mode) or passes
// the local vector through (chain head, bypass mode), adds lane-wise with
// signed saturation and hands the result to merge_io.
// Two-stage valid/ready pipeline: S1 holds the operand pair, S2 the sum.
// Ports:
//   clk_tl, rstn_tl          tile clock, async active-low reset
//   cfg_merge_en             1 = join with remote, 0 = local pass-through
//   cnt_clr_i                synchronous clear of vec_cnt_o and ovf_o
//   loc_data_i/valid/ready   local partial-sum vector
//   rmt_data_i/valid/ready   remote partial-sum vector (from merge_io)
//   out_data_o/valid/ready   merged vector (to merge_io)
//   vec_cnt_o                vectors emitted since reset or clear (wraps)
//   ovf_o                    sticky: some active lane saturated
// -----------------------------------------------------------------------------
module merge_accum
  import merge_accum_pkg::*;
#(
  parameter int XW          = DEF_XW,
  parameter int valid_chans = 128,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic              clk_tl,
  input  logic              rstn_tl,
  input  logic              cfg_merge_en,
  input  logic              cnt_clr_i,
  input  logic [QW*XW-1:0]  loc_data_i,
  input  logic              loc_valid_i,
  output logic              loc_ready_o,
  input  logic [QW*XW-1:0]  rmt_data_i,
  input  logic              rmt_valid_i,
  output logic              rmt_ready_o,
  output logic [QW*XW-1:0]  out_data_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CNT_W-1:0]  vec_cnt_o,
  output logic              ovf_o
);

  // S1: operand pair
  logic             r_v1;
  logic             r_merge;
  logic [QW*XW-1:0] r_loc;
  logic [QW*XW-1:0] r_rmt;
  // S2: saturated sum
  logic             r_v2;
  logic [QW*XW-1:0] r_out;
  // status
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;

  logic             w_s2_adv;
  logic             w_s1_free;
  logic             w_fire;
  logic [QW*XW-1:0] w_rmt_op;
  logic [QW*XW-1:0] w_sum;
  logic [XW-1:0]    w_lane_sat;

  assign w_s2_adv  = r_v1 & (~r_v2 | out_ready_i);
  assign w_s1_free = ~r_v1 | w_s2_adv;

  // Join: in merge mode both sides are consumed together or not at all, so
  // each ready also waits for the partner's valid.
  always_comb begin
    // NOTE: every signal gets a default before the branch, so no path through
    // this block can leave a value held (which would infer a latch).
    loc_ready_o = w_s1_free;
    rmt_ready_o = 1'b0;
    w_fire      = loc_valid_i & w_s1_free;
    if (cfg_merge_en) begin
      loc_ready_o = w_s1_free & rmt_valid_i;
      rmt_ready_o = w_s1_free & loc_valid_i;
      w_fire      = loc_valid_i & rmt_valid_i & w_s1_free;
    end
  end

  // NOTE: datapath registers are reset as well, because out_data_o must read
  // all zeros straight out of reset.
  always_ff @(posedge clk_tl or negedge rstn_tl) begin
    if (!rstn_tl) begin
      r_v1    <= 1'b0;
      r_merge <= 1'b0;
      r_loc   <= '0;
      r_rmt   <= '0;
    end else if (w_fire) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values,
      // independent of the order the always blocks are evaluated in.
      r_v1    <= 1'b1;
      r_merge <= cfg_merge_en;
      r_loc   <= loc_data_i;
      r_rmt   <= cfg_merge_en ? rmt_data_i : '0;
    end else if (w_s2_adv) begin
      r_v1    <= 1'b0;
    end
  end

  // A bypassed beat adds zero, so its remote half is ignored outright.
  assign w_rmt_op = r_merge ? r_rmt : '0;

  for (genvar g = 0; g < XW; g++) begin : g_lane
    lane_t w_lane_sum;
    logic  w_lane_ovf;

    sat_add_lane u_add (
      .i_a   (r_loc[g*QW +: QW]),
      .i_b   (w_rmt_op[g*QW +: QW]),
      .o_sum (w_lane_sum),
      .o_sat (w_lane_ovf)
    );

    // Lanes beyond valid_chans emit 0 and never report saturation.
    assign w_sum[g*QW +: QW] = (g < valid_chans) ? w_lane_sum : '0;
    assign w_lane_sat[g]     = (g < valid_chans) ? w_lane_ovf : 1'b0;
  end

  always_ff @(posedge clk_tl or negedge rstn_tl) begin
    if (!rstn_tl) begin
      r_v2  <= 1'b0;
      r_out <= '0;
    end else if (w_s2_adv) begin
      r_v2  <= 1'b1;
      r_out <= w_sum;
    end else if (out_ready_i) begin
      r_v2  <= 1'b0;
    end
  end

  // Clear has priority over a coincident handshake or saturation.
  always_ff @(posedge clk_tl or negedge rstn_tl) begin
    if (!rstn_tl) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (cnt_clr_i) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (r_v2 && out_ready_i) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_s2_adv && (|w_lane_sat)) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign out_valid_o = r_v2;
  assign out_data_o  = r_out;
  assign vec_cnt_o   = r_cnt;
  assign ovf_o       = r_ovf;

endmodule : merge_accum

// File: tb/tb_merge_accum.sv
`timescale 1ns/1ps
module tb_merge_accum;

  localparam int LW   = 8;            // lane width
  localparam int NL   = 8;            // lanes per vector
  localparam int VC   = 4;            // active lanes
  localparam int VW   = LW*NL;
  localparam int MAXV = 127;
  localparam int MINV = -128;

  logic          clk_tl = 1'b0;
  logic          rstn_tl = 1'b0;
  logic          cfg_merge_en;
  logic          cnt_clr_i;
  logic [VW-1:0] loc_data_i;
  logic          loc_valid_i;
  logic          loc_ready_o;
  logic [VW-1:0] rmt_data_i;
  logic          rmt_valid_i;
  logic          rmt_ready_o;
  logic [VW-1:0] out_data_o;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [15:0]   vec_cnt_o;
  logic          ovf_o;

  merge_accum #(.XW(NL), .valid_chans(VC), .CNT_W(16)) dut (
    .clk_tl       (clk_tl),
    .rstn_tl      (rstn_tl),
    .cfg_merge_en (cfg_merge_en),
    .cnt_clr_i    (cnt_clr_i),
    .loc_data_i   (loc_data_i),
    .loc_valid_i  (loc_valid_i),
    .loc_ready_o  (loc_ready_o),
    .rmt_data_i   (rmt_data_i),
    .rmt_valid_i  (rmt_valid_i),
    .rmt_ready_o  (rmt_ready_o),
    .out_data_o   (out_data_o),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .vec_cnt_o    (vec_cnt_o),
    .ovf_o        (ovf_o)
  );

  always #5 clk_tl = ~clk_tl;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [VW-1:0] pk(input int a0, input int a1, input int a2, input int a3,
                                       input int a4, input int a5, input int a6, input int a7);
    return {a7[7:0], a6[7:0], a5[7:0], a4[7:0], a3[7:0], a2[7:0], a1[7:0], a0[7:0]};
  endfunction

  // Reference: per active lane, integer sum (remote counted only when
  // merging) clamped to the signed 8-bit range; inactive lanes are 0.
  function automatic logic [VW-1:0] ref_sum(input logic [VW-1:0] l, input logic [VW-1:0] r,
                                            input bit m, output bit clamped);
    logic [VW-1:0] res;
    res = '0;
    clamped = 1'b0;
    for (int i = 0; i < VC; i++) begin
      logic signed [LW-1:0] a;
      logic signed [LW-1:0] b;
      int s;
      a = l[i*LW +: LW];
      b = r[i*LW +: LW];
      s = int'(a) + (m ? int'(b) : 0);
      if (s > MAXV) begin s = MAXV; clamped = 1'b1; end
      else if (s < MINV) begin s = MINV; clamped = 1'b1; end
      res[i*LW +: LW] = s[LW-1:0];
    end
    return res;
  endfunction

  typedef struct {
    string         name;
    logic [VW-1:0] loc;
    logic [VW-1:0] rmt;
    bit            merge;
    logic [VW-1:0] exp;
    bit            ovf;
  } vec_t;

  vec_t tbl[6];

  task automatic set_vec(input int i, input string n, input logic [VW-1:0] l, input logic [VW-1:0] r,
                         input bit m, input logic [VW-1:0] e, input bit o);
    tbl[i].name = n; tbl[i].loc = l; tbl[i].rmt = r; tbl[i].merge = m; tbl[i].exp = e; tbl[i].ovf = o;
  endtask

  task automatic pulse_clr();
    @(negedge clk_tl);
    cnt_clr_i = 1'b1;
    @(negedge clk_tl);
    cnt_clr_i = 1'b0;
  endtask

  // One isolated vector: accepted at the first edge, visible after the second.
  task automatic run_one(input vec_t v);
    pulse_clr();
    check({v.name, "_clr_cnt"}, vec_cnt_o, 0);
    check({v.name, "_clr_ovf"}, ovf_o, 0);
    cfg_merge_en = v.merge;
    loc_data_i   = v.loc;
    rmt_data_i   = v.rmt;
    loc_valid_i  = 1'b1;
    rmt_valid_i  = 1'b1;
    out_ready_i  = 1'b1;
    #1;
    check({v.name, "_loc_ready"}, loc_ready_o, 1);
    check({v.name, "_rmt_ready"}, rmt_ready_o, v.merge);
    @(negedge clk_tl);
    loc_valid_i = 1'b0;
    rmt_valid_i = 1'b0;
    check({v.name, "_lat1"}, out_valid_o, 0);
    @(negedge clk_tl);
    check({v.name, "_valid"}, out_valid_o, 1);
    check({v.name, "_data"}, out_data_o, v.exp);
    check({v.name, "_ovf"}, ovf_o, v.ovf);
    @(negedge clk_tl);
    check({v.name, "_cnt"}, vec_cnt_o, 1);
    check({v.name, "_drained"}, out_valid_o, 0);
  endtask

  // Random stream with random backpressure, checked against a queue model.
  task automatic run_stream(input int n, input bit merge, input string tag);
    logic [VW-1:0] expq[$];
    logic [VW-1:0] hold_data;
    bit            exp_ovf = 1'b0;
    bit            cl;
    bit            hold = 1'b0;
    bit            l_fire;
    bit            r_fire;
    int            sent = 0;
    int            got = 0;
    int            cyc = 0;
    pulse_clr();
    cfg_merge_en = merge;
    loc_valid_i  = 1'b0;
    rmt_valid_i  = 1'b0;
    while (got < n && cyc < 2000) begin
      if (!loc_valid_i && sent < n && $urandom_range(0, 3) != 0) begin
        loc_data_i  = {$urandom, $urandom};
        loc_valid_i = 1'b1;
      end
      if (merge) begin
        if (!rmt_valid_i && sent < n && $urandom_range(0, 3) != 0) begin
          rmt_data_i  = {$urandom, $urandom};
          rmt_valid_i = 1'b1;
        end
      end else begin
        rmt_data_i  = {$urandom, $urandom};
        rmt_valid_i = 1'($urandom_range(0, 1));
      end
      out_ready_i = 1'($urandom_range(0, 1));
      #1;
      if (hold) begin
        check({tag, "_stall_valid"}, out_valid_o, 1);
        check({tag, "_stall_data"}, out_data_o, hold_data);
      end
      hold      = out_valid_o & ~out_ready_i;
      hold_data = out_data_o;
      if (out_valid_o && out_ready_i) begin
        if (expq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL %s_extra: got unexpected output %h, expected none", tag, out_data_o);
        end else begin
          check({tag, "_data"}, out_data_o, expq.pop_front());
        end
        got++;
      end
      l_fire = loc_valid_i & loc_ready_o;
      r_fire = rmt_valid_i & rmt_ready_o;
      if (merge) check({tag, "_joint"}, r_fire, l_fire);
      else if (rmt_valid_i) check({tag, "_rmt_ready"}, rmt_ready_o, 0);
      if (l_fire) begin
        expq.push_back(ref_sum(loc_data_i, rmt_data_i, merge, cl));
        exp_ovf = exp_ovf | cl;
        sent++;
      end
      @(negedge clk_tl);
      cyc++;
      if (l_fire) loc_valid_i = 1'b0;
      if (r_fire) rmt_valid_i = 1'b0;
    end
    loc_valid_i = 1'b0;
    rmt_valid_i = 1'b0;
    if (cyc >= 2000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: got %0d outputs, expected %0d", tag, got, n);
    end
    check({tag, "_count"}, got, n);
    check({tag, "_vec_cnt"}, vec_cnt_o, n);
    check({tag, "_ovf"}, ovf_o, exp_ovf);
    check({tag, "_leftover"}, expq.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    cfg_merge_en = 1'b1;
    cnt_clr_i    = 1'b0;
    loc_data_i   = '0;
    rmt_data_i   = '0;
    loc_valid_i  = 1'b0;
    rmt_valid_i  = 1'b0;
    out_ready_i  = 1'b1;

    set_vec(0, "merge_basic", pk(10, -20, 3, 0, 0, 0, 0, 0), pk(5, 7, -3, 0, 0, 0, 0, 0), 1,
            pk(15, -13, 0, 0, 0, 0, 0, 0), 0);
    set_vec(1, "saturate", pk(100, -100, 0, 0, 0, 0, 0, 0), pk(100, -100, 0, 0, 0, 0, 0, 0), 1,
            pk(127, -128, 0, 0, 0, 0, 0, 0), 1);
    set_vec(2, "inactive", pk(1, 2, 3, 4, 50, 60, 70, 127), pk(1, 1, 1, 1, 100, 100, 100, 127), 1,
            pk(2, 3, 4, 5, 0, 0, 0, 0), 0);
    set_vec(3, "bypass", pk(-5, 60, 127, -128, 9, 9, 9, 9), pk(100, 100, 100, 100, 0, 0, 0, 0), 0,
            pk(-5, 60, 127, -128, 0, 0, 0, 0), 0);
    set_vec(4, "edge_exact", pk(127, -128, 64, -64, 0, 0, 0, 0), pk(0, 0, 63, -64, 0, 0, 0, 0), 1,
            pk(127, -128, 127, -128, 0, 0, 0, 0), 0);
    set_vec(5, "edge_clamp", pk(127, -128, -1, 1, 0, 0, 0, 0), pk(1, -1, -128, 127, 0, 0, 0, 0), 1,
            pk(127, -128, -128, 127, 0, 0, 0, 0), 1);

    // Reset state
    #12;
    check("rst_out_valid", out_valid_o, 0);
    check("rst_out_data", out_data_o, 0);
    check("rst_vec_cnt", vec_cnt_o, 0);
    check("rst_ovf", ovf_o, 0);
    rmt_valid_i = 1'b1; #1;
    check("rst_loc_ready_rv", loc_ready_o, 1);
    loc_valid_i = 1'b1; rmt_valid_i = 1'b0; #1;
    check("rst_loc_ready_norv", loc_ready_o, 0);
    check("rst_rmt_ready", rmt_ready_o, 1);
    loc_valid_i = 1'b0;
    @(negedge clk_tl);
    rstn_tl = 1'b1;

    for (int i = 0; i < 6; i++) run_one(tbl[i]);

    // Join skew: local waits for remote, one output after the join
    pulse_clr();
    cfg_merge_en = 1'b1;
    out_ready_i  = 1'b1;
    loc_data_i   = pk(1, 2, 3, 4, 0, 0, 0, 0);
    rmt_data_i   = pk(10, 20, 30, 40, 0, 0, 0, 0);
    loc_valid_i  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("skew_loc_ready", loc_ready_o, 0);
      check("skew_no_output", out_valid_o, 0);
      @(negedge clk_tl);
    end
    rmt_valid_i = 1'b1; #1;
    check("skew_join_loc_ready", loc_ready_o, 1);
    check("skew_join_rmt_ready", rmt_ready_o, 1);
    @(negedge clk_tl);
    loc_valid_i = 1'b0;
    rmt_valid_i = 1'b0;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (out_valid_o) begin
        seen++;
        check("skew_data", out_data_o, pk(11, 22, 33, 44, 0, 0, 0, 0));
      end
      @(negedge clk_tl);
    end
    check("skew_outputs", seen, 1);
    check("skew_vec_cnt", vec_cnt_o, 1);

    // Fill both stages, stall, then release with a coincident clear
    out_ready_i = 1'b0;
    rmt_data_i  = pk(10, 10, 10, 10, 0, 0, 0, 0);
    loc_data_i  = pk(1, 1, 1, 1, 0, 0, 0, 0);
    loc_valid_i = 1'b1;
    rmt_valid_i = 1'b1;
    @(negedge clk_tl);
    loc_data_i  = pk(2, 2, 2, 2, 0, 0, 0, 0);
    @(negedge clk_tl);
    loc_data_i  = pk(3, 3, 3, 3, 0, 0, 0, 0);
    #1;
    check("full_loc_ready", loc_ready_o, 0);
    check("full_rmt_ready", rmt_ready_o, 0);
    check("full_out_valid", out_valid_o, 1);
    check("full_data", out_data_o, pk(11, 11, 11, 11, 0, 0, 0, 0));
    @(negedge clk_tl);
    check("stall_data", out_data_o, pk(11, 11, 11, 11, 0, 0, 0, 0));
    check("stall_loc_ready", loc_ready_o, 0);
    out_ready_i = 1'b1;
    cnt_clr_i   = 1'b1;
    #1;
    check("release_loc_ready", loc_ready_o, 1);
    check("release_rmt_ready", rmt_ready_o, 1);
    @(negedge clk_tl);
    cnt_clr_i   = 1'b0;
    out_ready_i = 1'b0;
    loc_valid_i = 1'b0;
    rmt_valid_i = 1'b0;
    check("shift_data", out_data_o, pk(12, 12, 12, 12, 0, 0, 0, 0));
    check("clr_beats_handshake", vec_cnt_o, 0);

    // Asynchronous reset with both stages occupied
    rmt_valid_i = 1'b1;
    #1;
    rstn_tl = 1'b0;
    #1;
    check("midrst_out_valid", out_valid_o, 0);
    check("midrst_out_data", out_data_o, 0);
    check("midrst_vec_cnt", vec_cnt_o, 0);
    check("midrst_ovf", ovf_o, 0);
    check("midrst_loc_ready", loc_ready_o, 1);
    check("midrst_rmt_ready", rmt_ready_o, 0);
    cfg_merge_en = 1'b0; rmt_valid_i = 1'b0; loc_valid_i = 1'b1; #1;
    check("midrst_byp_loc_ready", loc_ready_o, 1);
    check("midrst_byp_rmt_ready", rmt_ready_o, 0);
    loc_valid_i  = 1'b0;
    cfg_merge_en = 1'b1;
    @(negedge clk_tl);
    rstn_tl     = 1'b1;
    out_ready_i = 1'b1;
    repeat (3) @(negedge clk_tl);
    check("postrst_no_output", out_valid_o, 0);

    run_stream(8, 1'b1, "stream_merge");
    run_stream(20, 1'b0, "stream_bypass");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_merge_accum
